// File: rtl/tournament_selector_pkg.sv
// Shared GA definitions: default widths, selector FSM encoding,
// LFSR tap mask and default seed for the GA random sources.
package tournament_selector_pkg;

  localparam int GENE_W_DEF = 32;
  localparam int FIT_W_DEF  = 16;

  // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR map to
  // state bits 0,2,3,5; the XOR of those bits enters at bit 15.
  localparam logic [15:0] LFSR_TAPS     = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_PRESENT,
    ST_DONE
  } sel_state_t;

endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit Fibonacci LFSR with enable, reset to SEED.
// Ports: clk, rst (async, active-low), en, value (low OUT_W bits).
module ga_lfsr16
  import tournament_selector_pkg::*;
#(
  parameter logic [15:0] SEED  = LFSR_SEED_DEF,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] value
);

  logic [15:0] state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {^(state & LFSR_TAPS), state[15:1]};
    end
  end

  assign value = state[OUT_W-1:0];

endmodule

// File: rtl/tournament_selector.sv
// Tournament selection over population memory; emits parent pairs.
// Ports: start/num_pairs/busy/done, mem read port, parent valid/ready.
module tournament_selector
  import tournament_selector_pkg::*;
#(
  parameter int          GENE_W    = GENE_W_DEF,
  parameter int          FIT_W     = FIT_W_DEF,
  parameter int          ADDR_W    = 6,
  parameter int          TOUR_SIZE = 4,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        num_pairs,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [GENE_W-1:0] mem_gene,
  input  logic [FIT_W-1:0]  mem_fitness,
  output logic              parent_valid,
  input  logic              parent_ready,
  output logic [GENE_W-1:0] parent_gene0,
  output logic [GENE_W-1:0] parent_gene1
);

  localparam int NRD = 2 * TOUR_SIZE;
  localparam int CW  = $clog2(NRD);
  localparam logic [CW-1:0] LAST = CW'(NRD - 1);
  localparam logic [CW-1:0] B0   = CW'(TOUR_SIZE);

  sel_state_t state, state_nx;

  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     ret_idx;
  logic              ret_vld;
  logic              ret_b;
  logic              ret_first;
  logic [8:0]        pairs_left;
  logic              xfer;
  logic [ADDR_W-1:0] rnd_addr;
  logic [GENE_W-1:0] best_gene_a;
  logic [GENE_W-1:0] best_gene_b;
  logic [FIT_W-1:0]  best_fit_a;
  logic [FIT_W-1:0]  best_fit_b;

  ga_lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (ADDR_W)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_rd_en),
    .value (rnd_addr)
  );

  assign xfer = (state == ST_PRESENT) & parent_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    busy         = 1'b1;
    done         = 1'b0;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    parent_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = rnd_addr;
        if (issue_cnt == LAST) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_nx = ST_PRESENT;
      end
      ST_PRESENT: begin
        parent_valid = 1'b1;
        if (xfer) begin
          state_nx = (pairs_left == 9'd1) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt  <= '0;
      ret_idx    <= '0;
      ret_vld    <= 1'b0;
      pairs_left <= '0;
    end else begin
      ret_vld <= mem_rd_en;
      ret_idx <= issue_cnt;
      if (state == ST_FETCH) begin
        issue_cnt <= issue_cnt + CW'(1);
      end else begin
        issue_cnt <= '0;
      end
      if (state == ST_IDLE && start) begin
        // A request of 0 pairs means a full 256.
        pairs_left <= (num_pairs == 8'd0) ? 9'd256 : {1'b0, num_pairs};
      end else if (xfer) begin
        pairs_left <= pairs_left - 9'd1;
      end
    end
  end

  // Returns arrive one cycle after issue, so ret_idx names the read.
  assign ret_b     = (ret_idx >= B0);
  assign ret_first = (ret_idx == '0) || (ret_idx == B0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_gene_a <= '0;
      best_gene_b <= '0;
      best_fit_a  <= '0;
      best_fit_b  <= '0;
    end else if (ret_vld) begin
      // Strict compare: on a tie the earlier individual stays.
      if (!ret_b) begin
        if (ret_first || mem_fitness > best_fit_a) begin
          best_gene_a <= mem_gene;
          best_fit_a  <= mem_fitness;
        end
      end else begin
        if (ret_first || mem_fitness > best_fit_b) begin
          best_gene_b <= mem_gene;
          best_fit_b  <= mem_fitness;
        end
      end
    end
  end

  assign parent_gene0 = best_gene_a;
  assign parent_gene1 = best_gene_b;

endmodule

// File: tb/tb_tournament_selector.sv
// Self-checking bench for tournament_selector: vector table runs,
// back-pressure, 256-pair wrap and mid-fetch reset sequences.
module tb_tournament_selector;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_pairs = 8'd0;
  logic        busy;
  logic        done;
  logic        mem_rd_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_gene;
  logic [15:0] mem_fitness;
  logic        parent_valid;
  logic        parent_ready = 1'b0;
  logic [31:0] parent_gene0;
  logic [31:0] parent_gene1;

  always #5 clk = ~clk;

  tournament_selector dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_pairs    (num_pairs),
    .busy         (busy),
    .done         (done),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_gene     (mem_gene),
    .mem_fitness  (mem_fitness),
    .parent_valid (parent_valid),
    .parent_ready (parent_ready),
    .parent_gene0 (parent_gene0),
    .parent_gene1 (parent_gene1)
  );

  logic [31:0] gmem [64];
  logic [15:0] fmem [64];

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_gene    <= gmem[mem_addr];
      mem_fitness <= fmem[mem_addr];
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;

  logic [5:0]  addr_q [$];
  logic [63:0] pair_q [$];
  logic [15:0] mlfsr = 16'hACE1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic fill(input int mode);
    for (int a = 0; a < 64; a++) begin
      case (mode)
        0: begin
          fmem[a] = 16'(a);
          gmem[a] = 32'hA500_0000 | 32'(a);
        end
        1: begin
          fmem[a] = 16'h0050;
          gmem[a] = 32'(a);
        end
        default: begin
          fmem[a] = 16'($urandom_range(0, 15));
          gmem[a] = $urandom;
        end
      endcase
    end
  endtask

  // Reference model: expected addresses and winners per pair.
  task automatic plan(input int n);
    logic [31:0] bg [2];
    logic [15:0] bf [2];
    logic [5:0]  a;
    int          k;
    for (int p = 0; p < n; p++) begin
      for (int t = 0; t < 2 * T; t++) begin
        a = mlfsr[5:0];
        addr_q.push_back(a);
        mlfsr = lfsr_step(mlfsr);
        k = t / T;
        if (t % T == 0 || fmem[a] > bf[k]) begin
          bf[k] = fmem[a];
          bg[k] = gmem[a];
        end
      end
      pair_q.push_back({bg[0], bg[1]});
    end
  endtask

  logic        pv_q = 1'b0;
  logic        xf_q = 1'b0;
  logic [31:0] g0_q;
  logic [31:0] g1_q;
  logic [63:0] exp_pair;

  always @(negedge clk) begin
    if (!rst) begin
      pv_q <= 1'b0;
      xf_q <= 1'b0;
    end else begin
      if (mem_rd_en) begin
        if (addr_q.size() == 0) flag("spurious_read");
        else chk("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (parent_valid) chk("rd_en_in_present", mem_rd_en, 0);
      if (parent_valid && pv_q && !xf_q) begin
        chk("gene0_stable", parent_gene0, g0_q);
        chk("gene1_stable", parent_gene1, g1_q);
      end
      if (parent_valid && parent_ready) begin
        xfer_cnt++;
        if (pair_q.size() == 0) begin
          flag("unexpected_pair");
        end else begin
          exp_pair = pair_q.pop_front();
          chk("parent_gene0", parent_gene0, exp_pair[63:32]);
          chk("parent_gene1", parent_gene1, exp_pair[31:0]);
        end
      end
      if (done) done_cnt++;
      pv_q <= parent_valid;
      xf_q <= parent_valid & parent_ready;
      g0_q <= parent_gene0;
      g1_q <= parent_gene1;
    end
  end

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, parent_valid, 0);
    chk({tag, "_gene0"}, parent_gene0, 0);
    chk({tag, "_gene1"}, parent_gene1, 0);
  endtask

  task automatic run(input logic [7:0] np, input int stall,
                     input bit poke, input int exp_xfers,
                     input int exp_lat, input bit first);
    int lat;
    int guard;
    plan((np == 8'd0) ? 256 : int'(np));
    xfer_cnt = 0;
    done_cnt = 0;
    parent_ready = (stall == 0);
    @(posedge clk) #1;
    start = 1'b1;
    num_pairs = np;
    @(posedge clk) #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (first) begin
      chk("first_rd_en", mem_rd_en, 1);
      chk("first_addr", mem_addr, 6'h21);
    end
    lat = 1;
    while (!parent_valid && lat < 50) begin
      @(posedge clk) #1;
      lat++;
    end
    chk("first_valid_cycle", lat, exp_lat);
    if (stall > 0) begin
      repeat (stall) @(posedge clk) #1;
      parent_ready = 1'b1;
      @(posedge clk) #1;
      chk("xfer_on_ready_rise", xfer_cnt, 1);
      chk("valid_drops", parent_valid, 0);
    end
    guard = 0;
    while (done_cnt == 0 && guard < 4000) begin
      @(posedge clk) #1;
      guard++;
      if (poke && (guard == 3 || guard == 15)) begin
        start = 1'b1;
        num_pairs = 8'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (done_cnt == 0) flag("done_timeout");
    repeat (3) @(posedge clk) #1;
    chk("xfers", xfer_cnt, exp_xfers);
    chk("done_pulses", done_cnt, 1);
    chk("idle_busy", busy, 0);
    chk("addr_q_left", addr_q.size(), 0);
    chk("pair_q_left", pair_q.size(), 0);
  endtask

  typedef struct {
    int         mode;
    logic [7:0] np;
    int         stall;
    bit         poke;
    int         exp_xfers;
    int         exp_lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{mode: 0, np: 8'd1, stall: 0, poke: 0, exp_xfers: 1,   exp_lat: 10};
    tbl[1] = '{mode: 1, np: 8'd1, stall: 0, poke: 0, exp_xfers: 1,   exp_lat: 10};
    tbl[2] = '{mode: 2, np: 8'd1, stall: 7, poke: 0, exp_xfers: 1,   exp_lat: 10};
    tbl[3] = '{mode: 2, np: 8'd3, stall: 0, poke: 1, exp_xfers: 3,   exp_lat: 10};
    tbl[4] = '{mode: 0, np: 8'd0, stall: 0, poke: 1, exp_xfers: 256, exp_lat: 10};
    tbl[5] = '{mode: 2, np: 8'd5, stall: 2, poke: 0, exp_xfers: 5,   exp_lat: 10};

    #12;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk) #1;
    chk_quiet("idle");

    for (int i = 0; i < 6; i++) begin
      fill(tbl[i].mode);
      run(tbl[i].np, tbl[i].stall, tbl[i].poke,
          tbl[i].exp_xfers, tbl[i].exp_lat, i == 0);
    end

    // Reset while the fifth read is being issued.
    fill(2);
    plan(2);
    parent_ready = 1'b1;
    @(posedge clk) #1;
    start = 1'b1;
    num_pairs = 8'd2;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (4) @(posedge clk) #1;
    chk("fifth_issue_rd_en", mem_rd_en, 1);
    rst = 1'b0;
    #1;
    chk_quiet("async_reset");
    addr_q.delete();
    pair_q.delete();
    mlfsr = 16'hACE1;
    xfer_cnt = 0;
    done_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(posedge clk) #1;
    chk("post_reset_done", done_cnt, 0);
    chk("post_reset_xfer", xfer_cnt, 0);
    chk("post_reset_busy", busy, 0);
    run(8'd2, 0, 0, 2, 10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tournament_selector.md
Name: tournament_selector

Overview:
- Producer side of the crossover datapath.
- Runs tournament selection over the population memory and delivers parent gene pairs (parent_gene0, parent_gene1) to the crossover engine through a valid/ready handshake.
- Each parent is the fittest of TOUR_SIZE pseudo-randomly addressed individuals.
- One start request produces num_pairs parent pairs, then a done pulse.

Parameters:
- GENE_W, 32, gene width in bits.
- FIT_W, 16, unsigned fitness width.
- ADDR_W, 6, population address width; population size is 2**ADDR_W.
- TOUR_SIZE, 4, individuals per tournament; legal range 2..8.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle request; sampled in IDLE only
- num_pairs  in  8  pairs to produce; captured with start; 0 is treated as 256
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse after the final pair is accepted
- mem_rd_en  out  1  population read strobe
- mem_addr  out  ADDR_W  population read address
- mem_gene  in  GENE_W  read data, valid exactly 1 cycle after mem_rd_en
- mem_fitness  in  FIT_W  read data, valid exactly 1 cycle after mem_rd_en
- parent_valid  out  1  pair available
- parent_ready  in  1  crossover engine accepts pair
- parent_gene0  out  GENE_W  tournament-A winner
- parent_gene1  out  GENE_W  tournament-B winner

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs go to 0; FSM goes to IDLE.
  - LFSR loads LFSR_SEED; pair counter and best registers clear.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances once per cycle in which mem_rd_en=1, and only then.
  - mem_addr = lfsr[ADDR_W-1:0] before the advance.
  - Not reseeded by start.
- FSM states: IDLE, FETCH, DRAIN, PRESENT, DONE.
- IDLE:
  - On start=1: capture num_pairs and go to FETCH.
  - start in any other state is ignored.
- FETCH:
  - Issues 2*TOUR_SIZE back-to-back reads, mem_rd_en=1 every cycle.
  - The first TOUR_SIZE reads belong to tournament A, the rest to tournament B.
  - After the last issue, go to DRAIN.
- DRAIN:
  - One cycle in which the final read return is compared.
  - Then go to PRESENT.
- Compare rule:
  - The first return of each tournament loads that tournament's best registers unconditionally.
  - A later return replaces best only if mem_fitness is strictly greater (unsigned). On a tie the earlier individual is kept.
- PRESENT:
  - parent_valid=1; parent_gene0/1 hold the A/B winners, stable until accepted.
  - Transfer occurs on a cycle with parent_valid & parent_ready.
  - On transfer, decrement the pair counter. If it reaches zero, go to DONE; otherwise go to FETCH.
  - parent_valid deasserts in the cycle after transfer.
  - A and B may select the same individual; this is permitted.
- DONE:
  - done=1 for one cycle, then go to IDLE.
- Latency (TOUR_SIZE=4, ready held high):
  - start sampled in cycle 0; mem_rd_en high in cycles 1..8.
  - parent_valid rises in cycle 10.
  - Each subsequent pair takes 10 cycles (FETCH 8, DRAIN 1, PRESENT 1).
- busy=1 in FETCH, DRAIN, PRESENT and DONE.
- Mid-operation reset returns the block to IDLE immediately. No partial pair or done pulse is emitted afterwards.

Decomposition:
- Shared GA package holds: GENE_W and FIT_W defaults, the FSM state encoding, the LFSR tap constant, and the default seed. These are reused by the crossover and mutation engines.
- One natural sub-module, ga_lfsr16: a 16-bit LFSR with enable, async active-low reset, and seed parameter. It is reusable as the random source in the crossover selectors.

Test Plan:
- Reset/idle: hold rst low, then release → all outputs 0, busy=0, first mem_addr after start = 16'hACE1[5:0] = 6'h21.
- Single pair, distinct fitness: memory fitness = address value, start with num_pairs=1, ready=1 → parent_valid in cycle 10; each parent is the gene of the max address in its four reads (checked against a reference-model LFSR); done pulses exactly once.
- Tie-break: all fitness = 16'h0050, gene = address → parent_gene0 = gene at first A address, parent_gene1 = gene at first B address.
- Back-pressure: parent_ready low for 7 cycles in PRESENT → parent_valid and genes stable throughout, mem_rd_en=0, no LFSR advance; transfer occurs on the cycle ready rises.
- Multi-pair and wrap: num_pairs=0 → exactly 256 transfers, then done; start pulses while busy are ignored; no mem_addr outside 0..63.
- Reset mid-FETCH: assert rst during the 5th read issue → outputs 0 asynchronously; after release, a new start with num_pairs=2 gives 2 clean pairs and a restarted LFSR sequence.
